// File: rtl/simple_io_responder_if.sv
// Bundle of the CPU IN/OUT handshake and the external source/sink streams
// served by simple_io_responder.
interface simple_io_responder_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
);
  // CPU side
  logic                     out_req;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ack;
  logic                     in_req;
  logic [WIDTH-1:0]         in_data;
  logic                     in_ack;
  logic                     io_busy;
  // external sink (drained from the output FIFO)
  logic [WIDTH-1:0]         ext_out_data;
  logic                     ext_out_valid;
  logic                     ext_out_ready;
  // external source (one word per IN)
  logic [WIDTH-1:0]         ext_in_data;
  logic                     ext_in_valid;
  logic                     ext_in_ready;
  // FIFO occupancy, 0..DEPTH
  logic [$clog2(DEPTH):0]   out_count;

  // responder side
  modport slave (
    input  out_req, out_data, in_req, ext_out_ready, ext_in_data, ext_in_valid,
    output out_ack, in_data, in_ack, io_busy, ext_out_data, ext_out_valid,
           ext_in_ready, out_count
  );

  // CPU / environment side
  modport master (
    output out_req, out_data, in_req, ext_out_ready, ext_in_data, ext_in_valid,
    input  out_ack, in_data, in_ack, io_busy, ext_out_data, ext_out_valid,
           ext_in_ready, out_count
  );
endinterface

// File: rtl/simple_io_responder.sv
// Peripheral responder for the SIMPLE CPU IN/OUT instructions: OUT words are
// buffered in a small FIFO and drained to a valid/ready sink; each IN fetches
// one word from a valid/ready source. io_busy holds the CPU while a request
// is outstanding.
module simple_io_responder #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  simple_io_responder_if.slave   io
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_out_ack;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_in_data;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_state_nxt;

  // Full is judged on current state only, so a same-cycle pop never frees a
  // slot for a push; ~out_ack stops a second push while the CPU drops out_req.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = io.out_req & ~r_out_ack & ~w_full;
  assign w_pop   = ~w_empty & io.ext_out_ready;

  // FIFO storage write
  // NOTE: the data array carries no reset; occupancy is tracked by r_count,
  // so stale words are never presented as valid and the RAM stays resetless.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io.out_data;
  end

  // FIFO pointers, occupancy and the registered OUT acknowledge
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_ack <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_out_ack <= w_push;
    end
  end

  // IN path next-state decision
  // NOTE: the default assignment first guarantees no latch on any path.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (io.in_req & ~(r_state == ST_ACK)) w_state_nxt = ST_WAIT;
      ST_WAIT: if (io.ext_in_valid)                  w_state_nxt = ST_ACK;
      ST_ACK:                                        w_state_nxt = ST_IDLE;
      default:                                       w_state_nxt = ST_IDLE;
    endcase
  end

  // IN path state register and capture of the source word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_in_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_WAIT) && io.ext_in_valid) r_in_data <= io.ext_in_data;
    end
  end

  assign io.out_ack       = r_out_ack;
  assign io.out_count     = r_count;
  assign io.ext_out_valid = ~w_empty;
  assign io.ext_out_data  = r_mem[r_rd_ptr];
  assign io.ext_in_ready  = (r_state == ST_WAIT);
  assign io.in_ack        = (r_state == ST_ACK);
  assign io.in_data       = r_in_data;
  assign io.io_busy       = (io.out_req & ~r_out_ack)
                          | (io.in_req & ~(r_state == ST_ACK))
                          | (r_state == ST_WAIT);

endmodule

// File: tb/tb_simple_io_responder.sv
// Scoreboard bench for simple_io_responder: stimulus tasks queue expected
// words, a negedge monitor checks every cycle against a transaction-level
// model (occupancy count, outstanding-request flags, in-order word queues).
module tb_simple_io_responder;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  simple_io_responder_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  simple_io_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // scoreboard queues: words the sink / the CPU must see, in order
  logic [WIDTH-1:0] exp_out[$];
  logic [WIDTH-1:0] exp_in[$];

  // reference model state
  bit               m_live    = 0;
  int               m_count   = 0;
  bit               m_out_ack = 0;
  bit               m_in_wait = 0;
  bit               m_in_ack  = 0;
  logic [WIDTH-1:0] m_last_in = '0;
  int               rdy_cycles = 0;
  bit               rand_rdy  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // random sink backpressure during the random phase
  always @(posedge clk) begin
    #1;
    if (rand_rdy) bus.ext_out_ready = 1'($urandom_range(0, 1));
  end

  // monitor: compare, then advance the model by one cycle
  always @(negedge clk) begin
    bit push, pop, nw, na;
    if (m_live) begin
      check("out_count", 32'(bus.out_count), m_count);
      check("out_ack", bus.out_ack, m_out_ack);
      check("ext_out_valid", bus.ext_out_valid, m_count != 0);
      check("ext_in_ready", bus.ext_in_ready, m_in_wait);
      check("in_ack", bus.in_ack, m_in_ack);
      check("io_busy", bus.io_busy,
            (bus.out_req & ~m_out_ack) | (bus.in_req & ~m_in_ack) | m_in_wait);
      if (bus.ext_in_ready) rdy_cycles++;
      if (m_in_ack && !reset) begin
        if (exp_in.size() == 0) begin
          total++; bad++;
          $display("FAIL in_word: got %0h expected none", bus.in_data);
        end else m_last_in = exp_in.pop_front();
      end
      check("in_data", bus.in_data, m_last_in);
      if (m_count != 0 && bus.ext_out_ready && !reset) begin
        if (exp_out.size() == 0) begin
          total++; bad++;
          $display("FAIL out_word: got %0h expected none", bus.ext_out_data);
        end else check("ext_out_data", bus.ext_out_data, exp_out.pop_front());
      end
    end
    if (reset) begin
      m_live = 1; m_count = 0; m_out_ack = 0; m_in_wait = 0; m_in_ack = 0;
      m_last_in = '0;
      exp_out.delete();
      exp_in.delete();
    end else begin
      push = bus.out_req && !m_out_ack && (m_count < DEPTH);
      pop  = (m_count != 0) && bus.ext_out_ready;
      m_count = m_count + int'(push) - int'(pop);
      m_out_ack = push;
      na = m_in_wait && bus.ext_in_valid;
      nw = m_in_wait ? !bus.ext_in_valid : (!m_in_ack && bus.in_req);
      m_in_ack  = na;
      m_in_wait = nw;
    end
  end

  task automatic do_out(input logic [WIDTH-1:0] w, output int ack_cyc);
    bit got = 0;
    exp_out.push_back(w);
    bus.out_data = w;
    bus.out_req  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.out_ack) begin got = 1; break; end
    end
    ack_cyc = cyc;
    bus.out_req = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL out_ack_timeout: got none expected ack for %0h", w);
    end
  endtask

  task automatic do_in(input logic [WIDTH-1:0] w, input int dly, output int ack_cyc);
    bit got = 0;
    exp_in.push_back(w);
    bus.in_req       = 1'b1;
    bus.ext_in_valid = 1'b0;
    bus.ext_in_data  = WIDTH'($urandom);
    for (int i = 0; i < dly + 1; i++) begin
      @(posedge clk); #1;
      bus.ext_in_data = WIDTH'($urandom);
    end
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = w;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.in_ack) begin got = 1; break; end
    end
    ack_cyc = cyc;
    bus.in_req       = 1'b0;
    bus.ext_in_valid = 1'b0;
    bus.ext_in_data  = WIDTH'($urandom);
    if (!got) begin
      total++; bad++;
      $display("FAIL in_ack_timeout: got none expected ack for %0h", w);
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    bus.ext_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (exp_out.size() == 0 && bus.out_count == 0) begin done = 1; break; end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_out.size());
    end
  endtask

  initial begin
    int t0, oc, ic;
    // reset with random inputs
    bus.out_req       = 1'($urandom);
    bus.out_data      = WIDTH'($urandom);
    bus.in_req        = 1'($urandom);
    bus.ext_out_ready = 1'($urandom);
    bus.ext_in_data   = WIDTH'($urandom);
    bus.ext_in_valid  = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_count", 32'(bus.out_count), 0);
    check("rst_ext_out_valid", bus.ext_out_valid, 0);
    check("rst_in_data", bus.in_data, 0);
    check("rst_acks", {bus.out_ack, bus.in_ack, bus.ext_in_ready}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_req = 0; bus.in_req = 0; bus.ext_in_valid = 0; bus.ext_out_ready = 0;
    @(posedge clk); #1;

    // single OUT
    bus.ext_out_ready = 1'b1;
    do_out(16'h00A5, oc);
    check("single_valid", bus.ext_out_valid, 1);
    check("single_data", bus.ext_out_data, 16'h00A5);
    check("single_count1", 32'(bus.out_count), 1);
    @(posedge clk); #1;
    check("single_count0", 32'(bus.out_count), 0);

    // full stall: 5 OUTs into a 4-deep FIFO with the sink blocked
    bus.ext_out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) do_out(WIDTH'(i), oc);
    check("full_count", 32'(bus.out_count), 4);
    fork
      do_out(16'h0005, oc);
      begin
        repeat (3) begin @(posedge clk); #1; end
        check("full_busy", bus.io_busy, 1);
        check("full_no_ack", bus.out_ack, 0);
        check("full_count_hold", 32'(bus.out_count), 4);
        bus.ext_out_ready = 1'b1;
        @(posedge clk); #1;
        bus.ext_out_ready = 1'b0;
        check("full_after_pop", 32'(bus.out_count), 3);
        @(posedge clk); #1;
        check("fifth_ack", bus.out_ack, 1);
      end
    join
    wait_drain();

    // IN handshake with a slow source
    rdy_cycles = 0;
    do_in(16'hBEEF, 3, ic);
    check("in_ready_cycles", rdy_cycles, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("in_data_hold", bus.in_data, 16'hBEEF);

    // concurrent IN and OUT
    bus.ext_out_ready = 1'b1;
    t0 = cyc;
    fork
      do_out(16'h1234, oc);
      do_in(16'h5678, 0, ic);
    join
    check("conc_out_lat", oc - t0, 1);
    check("conc_in_lat", ic - t0, 2);
    wait_drain();

    // random traffic
    rand_rdy = 1;
    for (int it = 0; it < 40; it++) begin
      logic [WIDTH-1:0] wa, wb;
      wa = WIDTH'($urandom);
      wb = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0: do_out(wa, oc);
        1: do_in(wb, int'($urandom_range(0, 3)), ic);
        default: fork do_out(wa, oc); do_in(wb, int'($urandom_range(0, 3)), ic); join
      endcase
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_rdy = 0;
    #1;
    wait_drain();

    // reset mid-operation: FIFO holding 3, IN waiting on the source
    bus.ext_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_out(WIDTH'(16'hC0 + i), oc);
    bus.in_req = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_wait", bus.ext_in_ready, 1);
    check("pre_rst_count", 32'(bus.out_count), 3);
    reset = 1'b1;
    bus.in_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_count", 32'(bus.out_count), 0);
    check("mid_rst_idle", bus.ext_in_ready, 0);
    check("mid_rst_valid", bus.ext_out_valid, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("mid_rst_no_acks", {bus.out_ack, bus.in_ack}, 0);

    // recovery after reset
    bus.ext_out_ready = 1'b1;
    do_out(16'h7E57, oc);
    wait_drain();
    check("in_left", exp_in.size(), 0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
